// File: rtl/runway_allocator_if.sv
// Request/reply handshake bundle between the request-decode FSM (master)
// and the runway allocator (slave): one allocation channel and one release
// channel, each a held req with a one-cycle ack pulse.
interface runway_allocator_if #(
  parameter int NUM_RUNWAYS = 2,
  parameter int ID_WIDTH    = 4
);
  localparam int RW_W = $clog2(NUM_RUNWAYS);

  logic                alloc_req;
  logic [ID_WIDTH-1:0] alloc_id;
  logic                alloc_ack;
  logic                alloc_grant;
  logic [RW_W-1:0]     alloc_runway;

  logic                rel_req;
  logic [ID_WIDTH-1:0] rel_id;
  logic [RW_W-1:0]     rel_runway;
  logic                rel_ack;
  logic                rel_ok;

  modport master (
    output alloc_req, alloc_id, rel_req, rel_id, rel_runway,
    input  alloc_ack, alloc_grant, alloc_runway, rel_ack, rel_ok
  );

  modport slave (
    input  alloc_req, alloc_id, rel_req, rel_id, rel_runway,
    output alloc_ack, alloc_grant, alloc_runway, rel_ack, rel_ok
  );
endinterface

// File: rtl/runway_allocator.sv
// N-runway allocator: serves allocation/release requests over a req/ack
// handshake, tracks the owning plane ID per runway, rotates grants
// round-robin and skips closed runways.
// Optional feature macro: RUNWAY_TIMEOUT_EN -- force-frees a runway that has
// been held for TIMEOUT_CYCLES cycles and pulses timeout_evt for it.
module runway_allocator #(
  parameter  int NUM_RUNWAYS    = 2,
  parameter  int ID_WIDTH       = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int RW_W           = $clog2(NUM_RUNWAYS),
  localparam int CNT_W          = $clog2(NUM_RUNWAYS + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  runway_allocator_if.slave      bus,
  input  logic [NUM_RUNWAYS-1:0] runway_closed,
  output logic [NUM_RUNWAYS-1:0] runway_busy,
  output logic [CNT_W-1:0]       free_count,
  output logic [NUM_RUNWAYS-1:0] timeout_evt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_REL
  } state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [RW_W-1:0]       rwy_q;
  logic [RW_W-1:0]       rr_ptr_q;
  logic [NUM_RUNWAYS-1:0] busy_q, busy_d;
  logic [ID_WIDTH-1:0]   owner_q [NUM_RUNWAYS];
  logic                  alloc_ack_q, alloc_grant_q, rel_ack_q, rel_ok_q;
  logic [RW_W-1:0]       alloc_runway_q;
  logic [CNT_W-1:0]      free_count_q, free_count_d;
  logic [NUM_RUNWAYS-1:0] timeout_evt_q;

  logic                  dup_id, found, grant_now, rel_match;
  logic [RW_W-1:0]       found_idx, cand;
  logic [NUM_RUNWAYS-1:0] expire;

  // Round-robin successor of a runway index, wrapping after the last runway.
  function automatic logic [RW_W-1:0] next_idx(input logic [RW_W-1:0] p);
    return (int'(p) == NUM_RUNWAYS - 1) ? '0 : p + 1'b1;
  endfunction

  // Duplicate-owner check and round-robin search, both on cycle-start state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    dup_id    = 1'b0;
    found     = 1'b0;
    found_idx = '0;
    cand      = rr_ptr_q;
    for (int i = 0; i < NUM_RUNWAYS; i++) begin
      if (busy_q[i] && (owner_q[i] == id_q)) dup_id = 1'b1;
    end
    for (int k = 0; k < NUM_RUNWAYS; k++) begin
      if (!found && !busy_q[cand] && !runway_closed[cand]) begin
        found     = 1'b1;
        found_idx = cand;
      end
      cand = next_idx(cand);
    end
  end

  assign grant_now = found && !dup_id;
  assign rel_match = (int'(rwy_q) < NUM_RUNWAYS) && busy_q[rwy_q] && (owner_q[rwy_q] == id_q);

  // Next occupancy: timeouts clear, a grant sets, a matching release clears.
  always_comb begin
    busy_d = busy_q & ~expire;
    if ((state_q == ST_ALLOC) && grant_now) busy_d[found_idx] = 1'b1;
    if ((state_q == ST_REL) && rel_match)   busy_d[rwy_q]     = 1'b0;
  end

  // Runways neither busy nor closed, registered one cycle behind the inputs.
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < NUM_RUNWAYS; i++) begin
      if (!busy_q[i] && !runway_closed[i]) free_count_d = free_count_d + 1'b1;
    end
  end

`ifdef RUNWAY_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] occ_cnt_q [NUM_RUNWAYS];

  // A runway expires once its occupancy counter has reached the limit.
  always_comb begin
    for (int i = 0; i < NUM_RUNWAYS; i++) begin
      expire[i] = busy_q[i] && (occ_cnt_q[i] == TO_W'(TIMEOUT_CYCLES - 1));
    end
  end

  // Per-runway occupancy counters, cleared on grant, counting while busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_RUNWAYS; i++) occ_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RUNWAYS; i++) begin
        if ((state_q == ST_ALLOC) && grant_now && (int'(found_idx) == i)) begin
          occ_cnt_q[i] <= '0;
        end else if (busy_q[i] && !expire[i]) begin
          occ_cnt_q[i] <= occ_cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  // Without the timeout feature runways are freed only by release.
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = '0;
`endif

  // Request FSM with registered replies; also registers occupancy and status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      id_q           <= '0;
      rwy_q          <= '0;
      rr_ptr_q       <= '0;
      busy_q         <= '0;
      alloc_ack_q    <= 1'b0;
      alloc_grant_q  <= 1'b0;
      alloc_runway_q <= '0;
      rel_ack_q      <= 1'b0;
      rel_ok_q       <= 1'b0;
      free_count_q   <= '0;
      timeout_evt_q  <= '0;
      // NOTE: the owner table is small and must read as zero after reset, so it is reset like any register.
      for (int i = 0; i < NUM_RUNWAYS; i++) owner_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      alloc_ack_q   <= 1'b0;
      rel_ack_q     <= 1'b0;
      busy_q        <= busy_d;
      free_count_q  <= free_count_d;
      timeout_evt_q <= expire;
      case (state_q)
        ST_IDLE: begin
          // While an ack is on the wire the requester still holds req; wait one cycle for it to drop.
          if (!alloc_ack_q && !rel_ack_q) begin
            if (bus.rel_req) begin
              id_q    <= bus.rel_id;
              rwy_q   <= bus.rel_runway;
              state_q <= ST_REL;
            end else if (bus.alloc_req) begin
              id_q    <= bus.alloc_id;
              state_q <= ST_ALLOC;
            end
          end
        end
        ST_ALLOC: begin
          alloc_ack_q    <= 1'b1;
          alloc_grant_q  <= grant_now;
          alloc_runway_q <= grant_now ? found_idx : '0;
          if (grant_now) begin
            owner_q[found_idx] <= id_q;
            rr_ptr_q           <= next_idx(found_idx);
          end
          state_q <= ST_IDLE;
        end
        ST_REL: begin
          rel_ack_q <= 1'b1;
          rel_ok_q  <= rel_match;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.alloc_ack    = alloc_ack_q;
  assign bus.alloc_grant  = alloc_grant_q;
  assign bus.alloc_runway = alloc_runway_q;
  assign bus.rel_ack      = rel_ack_q;
  assign bus.rel_ok       = rel_ok_q;
  assign runway_busy      = busy_q;
  assign free_count       = free_count_q;
  assign timeout_evt      = timeout_evt_q;

endmodule

// File: tb/tb_runway_allocator.sv
// Directed bench for runway_allocator with four runways.
module tb_runway_allocator;
  localparam int N  = 4;
`ifdef RUNWAY_TIMEOUT_EN
  // Long enough that the earlier scenarios never hit a forced free.
  localparam int TO = 64;
`else
  localparam int TO = 8;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] runway_closed = '0;
  logic [N-1:0] runway_busy;
  logic [2:0]   free_count;
  logic [N-1:0] timeout_evt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int last_lat;

  runway_allocator_if #(.NUM_RUNWAYS(N), .ID_WIDTH(4)) bus ();

  runway_allocator #(.NUM_RUNWAYS(N), .ID_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .runway_closed (runway_closed),
    .runway_busy   (runway_busy),
    .free_count    (free_count),
    .timeout_evt   (timeout_evt)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic alloc_chk(input string tag, input logic [3:0] id, input logic exp_grant,
                           input logic chk_rwy, input logic [1:0] exp_rwy);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    bus.alloc_id  = id;
    bus.alloc_req = 1'b1;
    while (!got && n < 20) begin
      tick();
      n++;
      got = bus.alloc_ack;
    end
    bus.alloc_req = 1'b0;
    last_lat = n;
    check({tag, "_ack"}, got, 1);
    if (got) begin
      check({tag, "_grant"}, bus.alloc_grant, exp_grant);
      if (chk_rwy) check({tag, "_runway"}, bus.alloc_runway, exp_rwy);
    end
  endtask

  task automatic rel_chk(input string tag, input logic [3:0] id, input logic [1:0] rwy,
                         input logic exp_ok);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    bus.rel_id     = id;
    bus.rel_runway = rwy;
    bus.rel_req    = 1'b1;
    while (!got && n < 20) begin
      tick();
      n++;
      got = bus.rel_ack;
    end
    bus.rel_req = 1'b0;
    check({tag, "_ack"}, got, 1);
    if (got) check({tag, "_ok"}, bus.rel_ok, exp_ok);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    logic rel_seen, alloc_seen, ok_v, grant_v, evt_any;
    logic [1:0] rwy_v;
    int   rel_cyc, alloc_cyc, cyc, evt_cyc;

    bus.alloc_req = 1'b0;
    bus.alloc_id = '0;
    bus.rel_req = 1'b0;
    bus.rel_id = '0;
    bus.rel_runway = '0;

    // Reset state.
    tick();
    tick();
    check("rst_busy", runway_busy, 4'b0000);
    check("rst_free", free_count, 0);
    check("rst_alloc_ack", bus.alloc_ack, 0);
    check("rst_rel_ack", bus.rel_ack, 0);
    check("rst_tevt", timeout_evt, 0);
    reset_n = 1'b1;
    tick();
    tick();
    check("free_after_rst", free_count, 4);

    // 1: four back-to-back allocations fill runways in order, fifth rejected.
    alloc_chk("t1_id1", 4'd1, 1'b1, 1'b1, 2'd0);
    check("t1_latency", last_lat, 2);
    alloc_chk("t1_id2", 4'd2, 1'b1, 1'b1, 2'd1);
    alloc_chk("t1_id3", 4'd3, 1'b1, 1'b1, 2'd2);
    alloc_chk("t1_id4", 4'd4, 1'b1, 1'b1, 2'd3);
    tick();
    tick();
    check("t1_busy", runway_busy, 4'b1111);
    check("t1_free", free_count, 0);
    alloc_chk("t1_id5", 4'd5, 1'b0, 1'b1, 2'd0);

    // 2: duplicate ID rejected.
    do_reset();
    alloc_chk("t2_first", 4'd7, 1'b1, 1'b1, 2'd0);
    alloc_chk("t2_dup", 4'd7, 1'b0, 1'b0, 2'd0);
    tick();
    check("t2_busy", runway_busy, 4'b0001);

    // 3: release needs matching owner; releasing a free runway fails.
    alloc_chk("t3_id3", 4'd3, 1'b1, 1'b1, 2'd1);
    rel_chk("t3_wrong_id", 4'd4, 2'd1, 1'b0);
    tick();
    check("t3_still_busy", runway_busy, 4'b0011);
    rel_chk("t3_owner", 4'd3, 2'd1, 1'b1);
    tick();
    check("t3_freed", runway_busy, 4'b0001);
    rel_chk("t3_not_busy", 4'd3, 2'd1, 1'b0);

    // Reset in the middle of an allocation: no ack, everything freed.
    bus.alloc_id  = 4'd15;
    bus.alloc_req = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    bus.alloc_req = 1'b0;
    check("midrst_busy", runway_busy, 4'b0000);
    tick();
    tick();
    check("midrst_no_ack", bus.alloc_ack, 0);
    reset_n = 1'b1;
    tick();
    tick();

    // 4: closure mask steers grants; closing a busy runway keeps it busy.
    runway_closed = 4'b0011;
    alloc_chk("t4_id9", 4'd9, 1'b1, 1'b1, 2'd2);
    runway_closed = 4'b0111;
    tick();
    tick();
    check("t4_busy_closed", runway_busy, 4'b0100);
    check("t4_free", free_count, 1);
    alloc_chk("t4_id10", 4'd10, 1'b1, 1'b1, 2'd3);
    alloc_chk("t4_none", 4'd11, 1'b0, 1'b1, 2'd0);
    tick();
    check("t4_free_zero", free_count, 0);
    runway_closed = 4'b0000;
    alloc_chk("t4_wrap", 4'd11, 1'b1, 1'b1, 2'd0);
    alloc_chk("t4_id12", 4'd12, 1'b1, 1'b1, 2'd1);
    tick();
    check("t4_all_busy", runway_busy, 4'b1111);

    // 5: release and allocation together -- release first, freed runway granted.
    tick();
    bus.rel_id     = 4'd10;
    bus.rel_runway = 2'd3;
    bus.rel_req    = 1'b1;
    bus.alloc_id   = 4'd13;
    bus.alloc_req  = 1'b1;
    rel_seen = 1'b0; alloc_seen = 1'b0; ok_v = 1'b0; grant_v = 1'b0; rwy_v = '0;
    rel_cyc = 0; alloc_cyc = 0; cyc = 0;
    while (!alloc_seen && cyc < 30) begin
      tick();
      cyc++;
      if (bus.rel_ack && !rel_seen) begin
        rel_seen = 1'b1; rel_cyc = cyc; ok_v = bus.rel_ok; bus.rel_req = 1'b0;
      end
      if (bus.alloc_ack) begin
        alloc_seen = 1'b1; alloc_cyc = cyc; grant_v = bus.alloc_grant;
        rwy_v = bus.alloc_runway; bus.alloc_req = 1'b0;
      end
    end
    bus.rel_req   = 1'b0;
    bus.alloc_req = 1'b0;
    check("t5_rel_seen", rel_seen, 1);
    check("t5_alloc_seen", alloc_seen, 1);
    check("t5_rel_ok", ok_v, 1);
    check("t5_gap", alloc_cyc - rel_cyc, 3);
    check("t5_grant", grant_v, 1);
    check("t5_runway", rwy_v, 2'd3);

    // 6: occupancy timeout (forced free only with the feature enabled).
    do_reset();
    alloc_chk("t6_grant", 4'd1, 1'b1, 1'b1, 2'd0);
    evt_any = 1'b0;
    evt_cyc = 0;
`ifdef RUNWAY_TIMEOUT_EN
    for (int i = 1; i <= TO + 5 && !evt_any; i++) begin
      tick();
      if (timeout_evt != '0) begin
        evt_any = 1'b1;
        evt_cyc = i;
        check("t6_evt", timeout_evt, 4'b0001);
        check("t6_busy_freed", runway_busy, 4'b0000);
      end
    end
    check("t6_evt_seen", evt_any, 1);
    check("t6_evt_cycle", evt_cyc, TO);
    tick();
    check("t6_evt_pulse", timeout_evt, 4'b0000);
`else
    for (int i = 1; i <= TO + 4; i++) begin
      tick();
      if (timeout_evt != '0) evt_any = 1'b1;
    end
    check("t6_no_evt", evt_any, 0);
    check("t6_still_busy", runway_busy, 4'b0001);
    check("t6_evt_cycle", evt_cyc, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
